gpio_cmd_ctrl: RTL and testbench

GPIO_CMD_CTRL -- requirements
Module: gpio_cmd_ctrl

---
 rtl/gpio_cmd_ctrl_if.sv | 26 ++
 rtl/gpio_cmd_ctrl.sv | 111 +++++++++++
 tb/tb_gpio_cmd_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gpio_cmd_ctrl_if.sv
// gpio_cmd_ctrl_if: byte-stream handshake between the UART and the GPIO command controller
interface gpio_cmd_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    // UART side: delivers received bytes and transmitter status, consumes transmit requests
    modport master (
        output rx_valid,
        output rx_data,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );

    // Controller side: consumes received bytes, issues transmit requests
    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_busy,
        output tx_start,
        output tx_data
    );
endinterface

// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl: UART byte-command decoder driving four GPIO output banks and reading four input banks
module gpio_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic               clk,
    input  logic               rst_n,
    gpio_cmd_ctrl_if.slave     uart,
    input  logic [31:0]        gpin,
    output logic [31:0]        gpout,
    output logic [7:0]         err_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DATA = 2'd1;
    localparam logic [1:0] TX_WAIT   = 2'd2;
    localparam logic [1:0] TX_HOLD   = 2'd3;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    logic [1:0]    state;
    logic [1:0]    nextState;
    logic [TW-1:0] timer;
    logic [1:0]    wrBank;

    logic [1:0] rxOp;
    logic [1:0] rxBank;
    logic       cmdWrite;
    logic       cmdResp;
    logic       cmdIllegal;
    logic       dataAccept;
    logic       timeoutHit;
    logic       overrun;
    logic       txGo;
    logic       errInc;

    assign rxOp   = uart.rx_data[7:6];
    assign rxBank = uart.rx_data[1:0];

    // Events seen this cycle; a data byte always beats a coinciding timeout
    assign cmdWrite   = (state == IDLE) && uart.rx_valid && (rxOp == OP_WRITE);
    assign cmdResp    = (state == IDLE) && uart.rx_valid && (rxOp == OP_READ || rxOp == OP_ILL);
    assign cmdIllegal = cmdResp && (rxOp == OP_ILL);
    assign dataAccept = (state == WAIT_DATA) && uart.rx_valid;
    assign timeoutHit = (state == WAIT_DATA) && !uart.rx_valid && (timer == TLAST);
    assign overrun    = uart.rx_valid && (state == TX_WAIT || state == TX_HOLD);
    assign txGo       = (state == TX_WAIT) && !uart.tx_busy;
    assign errInc     = cmdIllegal || overrun || timeoutHit;

    // Next-state selection; NOP commands simply leave the FSM in IDLE
    always_comb begin
        nextState = state;
        case (state)
            IDLE:      nextState = cmdWrite ? WAIT_DATA : (cmdResp ? TX_WAIT : IDLE);
            WAIT_DATA: nextState = dataAccept ? TX_WAIT : (timeoutHit ? IDLE : WAIT_DATA);
            TX_WAIT:   nextState = txGo ? TX_HOLD : TX_WAIT;
            default:   nextState = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Idle-gap counter for the data byte; zero everywhere outside WAIT_DATA so entry starts clean
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) timer <= '0;
        else        timer <= (state == WAIT_DATA && !uart.rx_valid && !timeoutHit) ? timer + 1'b1 : '0;
    end

    // Remember which bank a WRITE targets until its data byte arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        wrBank <= 2'd0;
        else if (cmdWrite) wrBank <= rxBank;
    end

    // Output banks change only on the edge that accepts a WRITE data byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          gpout <= 32'h0;
        else if (dataAccept) gpout[{wrBank, 3'b000} +: 8] <= uart.rx_data;
    end

    // Response byte is loaded once per command and otherwise held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          uart.tx_data <= 8'h00;
        else if (cmdResp)    uart.tx_data <= cmdIllegal ? NAK_BYTE : gpin[{rxBank, 3'b000} +: 8];
        else if (dataAccept) uart.tx_data <= ACK_BYTE;
    end

    // One-cycle transmit request as soon as the transmitter is free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uart.tx_start <= 1'b0;
        else        uart.tx_start <= txGo;
    end

    // Protocol errors are mutually exclusive per cycle, so a single saturating increment suffices
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             err_count <= 8'h00;
        else if (errInc && err_count != 8'hFF) err_count <= err_count + 8'h01;
    end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb_gpio_cmd_ctrl: directed checks of command decode, timing, timeout, errors and reset
module tb_gpio_cmd_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpin;
    logic [31:0] gpout;
    logic [7:0]  err_count;
    int          nChecks = 0;
    int          nBad = 0;
    int          pulseCnt = 0;
    int          p0;

    gpio_cmd_ctrl_if ifc();

    gpio_cmd_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .uart(ifc),
        .gpin(gpin),
        .gpout(gpout),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Count tx_start pulses using the value held during the cycle ending at this edge
    always @(posedge clk) if (ifc.tx_start === 1'b1) pulseCnt <= pulseCnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = b;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
    endtask

    initial begin
        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        ifc.tx_busy  = 1'b0;
        gpin         = 32'h0;
        tick(3);
        check("rst_gpout", gpout, 32'h0);
        check("rst_tx_start", {31'h0, ifc.tx_start}, 32'h0);
        check("rst_tx_data", {24'h0, ifc.tx_data}, 32'h0);
        check("rst_err", {24'h0, err_count}, 32'h0);
        rst_n = 1'b1;

        // WRITE bank 2
        p0 = pulseCnt;
        sendByte(8'h42);
        sendByte(8'h3C);
        check("wr_gpout", gpout, 32'h003C_0000);
        check("wr_tx_data", {24'h0, ifc.tx_data}, 32'h0000_00A5);
        tick(4);
        check("wr_pulses", pulseCnt - p0, 1);

        // READ bank 1, minimum latency
        gpin = 32'h0000_7E00;
        @(negedge clk);
        ifc.rx_valid = 1'b1;
        ifc.rx_data  = 8'h81;
        @(negedge clk);
        ifc.rx_valid = 1'b0;
        gpin = 32'h0000_1100;
        check("rd_start_n1", {31'h0, ifc.tx_start}, 32'h0);
        @(negedge clk);
        check("rd_start_n2", {31'h0, ifc.tx_start}, 32'h1);
        check("rd_tx_data", {24'h0, ifc.tx_data}, 32'h0000_007E);
        @(negedge clk);
        check("rd_start_n3", {31'h0, ifc.tx_start}, 32'h0);
        tick(2);

        // READ bank 3 while the transmitter is busy
        ifc.tx_busy = 1'b1;
        gpin = 32'h5A00_0000;
        p0 = pulseCnt;
        sendByte(8'h83);
        tick(50);
        check("busy_no_pulse", pulseCnt - p0, 0);
        ifc.tx_busy = 1'b0;
        @(negedge clk);
        check("busy_start", {31'h0, ifc.tx_start}, 32'h1);
        tick(3);
        check("busy_pulses", pulseCnt - p0, 1);
        check("busy_tx_data", {24'h0, ifc.tx_data}, 32'h0000_005A);

        // WRITE timeout after 16 idle cycles
        p0 = pulseCnt;
        sendByte(8'h40);
        tick(15);
        check("to_err_before", {24'h0, err_count}, 32'h0);
        tick(1);
        check("to_err_after", {24'h0, err_count}, 32'h1);
        check("to_gpout", gpout, 32'h003C_0000);
        tick(3);
        check("to_pulses", pulseCnt - p0, 0);

        // Data byte arriving in the timeout cycle wins
        p0 = pulseCnt;
        sendByte(8'h41);
        tick(14);
        sendByte(8'h77);
        check("race_err", {24'h0, err_count}, 32'h1);
        check("race_gpout", gpout, 32'h003C_7700);
        tick(4);
        check("race_pulses", pulseCnt - p0, 1);
        check("race_tx_data", {24'h0, ifc.tx_data}, 32'h0000_00A5);

        // Illegal opcode, overrun, saturation
        @(negedge clk);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("rst2_err", {24'h0, err_count}, 32'h0);
        check("rst2_gpout", gpout, 32'h0);
        ifc.tx_busy = 1'b1;
        p0 = pulseCnt;
        sendByte(8'hC0);
        check("ill_tx_data", {24'h0, ifc.tx_data}, 32'h0000_00EE);
        check("ill_err", {24'h0, err_count}, 32'h1);
        sendByte(8'h81);
        check("ovr_err", {24'h0, err_count}, 32'h2);
        check("ovr_tx_data", {24'h0, ifc.tx_data}, 32'h0000_00EE);
        for (int i = 0; i < 252; i++) sendByte(8'h81);
        check("sat_fe", {24'h0, err_count}, 32'h0000_00FE);
        sendByte(8'h81);
        check("sat_ff", {24'h0, err_count}, 32'h0000_00FF);
        for (int i = 0; i < 45; i++) sendByte(8'h81);
        check("sat_hold", {24'h0, err_count}, 32'h0000_00FF);
        ifc.tx_busy = 1'b0;
        tick(4);
        check("ill_pulses", pulseCnt - p0, 1);

        // Reset in the middle of a WRITE
        sendByte(8'h40);
        sendByte(8'h99);
        tick(4);
        check("pre_rst_gpout", gpout, 32'h0000_0099);
        sendByte(8'h43);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gpout", gpout, 32'h0);
        check("arst_err", {24'h0, err_count}, 32'h0);
        check("arst_tx_data", {24'h0, ifc.tx_data}, 32'h0);
        check("arst_tx_start", {31'h0, ifc.tx_start}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulseCnt;
        sendByte(8'h43);
        sendByte(8'h11);
        check("post_rst_gpout", gpout, 32'h1100_0000);
        tick(4);
        check("post_rst_pulses", pulseCnt - p0, 1);
        check("post_rst_tx_data", {24'h0, ifc.tx_data}, 32'h0000_00A5);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end
endmodule
